l1_cache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate L1 cache controller that sequences the 256-bit line data array. Holds per-set tag/valid/dirty state, resolves CPU word accesses as hit or miss, and drives the physical-memory line interface for write-back and refill. Sits between the pipeline memory stage (or arbiter) and the line-granular physical memory. Line = 32 bytes; address split is tag [31:5+s_index], index [4+s_index:5], word [4:2].

---
 rtl/l1_cache_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_l1_cache_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_cache_ctrl.sv
// l1_cache_ctrl: direct-mapped, write-back, write-allocate L1 cache controller.
// Keeps per-set tag/valid/dirty state, resolves CPU word accesses as hits or
// misses, and sequences write-back and refill of 256-bit lines over the
// physical-memory interface. The line data array itself lives outside.
// Optional feature macro: CACHE_PERF_CTR_EN (hit/miss performance counters).
module l1_cache_ctrl #(
    parameter int s_index = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         mem_address,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [3:0]          mem_byte_enable,
    input  logic [31:0]         mem_wdata,
    output logic [31:0]         mem_rdata,
    output logic                mem_resp,
    output logic [31:0]         pmem_address,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [255:0]        pmem_wdata,
    input  logic [255:0]        pmem_rdata,
    input  logic                pmem_resp,
    output logic [s_index-1:0]  da_rindex,
    output logic [s_index-1:0]  da_windex,
    output logic [31:0]         da_write_en,
    output logic [255:0]        da_datain,
    input  logic [255:0]        da_dataout,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
);

    localparam int tag_w = 27 - s_index;
    localparam int sets  = 1 << s_index;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_t;

    state_t             state_reg;
    logic [tag_w-1:0]   addr_tag;
    logic [s_index-1:0] idx;
    logic [2:0]         word;
    logic               req;
    logic               hit;
    logic               refill_done;
    logic               write_hit;
    logic [tag_w-1:0]   tag_vec [sets];
    logic [sets-1:0]    valid_vec;
    logic [sets-1:0]    dirty_vec;
    logic               unused_addr_bits;

    assign addr_tag         = mem_address[31:5+s_index];
    assign idx              = mem_address[4+s_index:5];
    assign word             = mem_address[4:2];
    assign unused_addr_bits = ^mem_address[1:0];

    // The data array is always addressed by the request's index field.
    assign da_rindex = idx;
    assign da_windex = idx;

    assign req         = mem_read | mem_write;
    assign hit         = valid_vec[idx] & (tag_vec[idx] == addr_tag) & req;
    assign refill_done = (state_reg == FETCH) & pmem_resp;
    assign write_hit   = (state_reg == IDLE) & hit & mem_write;

    // Per-set tag/valid/dirty registers; only the addressed set ever changes.
    for (genvar gi = 0; gi < sets; gi++) begin : g_set
        logic [tag_w-1:0] tag_reg;
        logic             valid_reg;
        logic             dirty_reg;

        // Install on refill completion, mark dirty on a write hit.
        always_ff @(posedge clk) begin
            if (rst) begin
                tag_reg   <= '0;
                valid_reg <= 1'b0;
                dirty_reg <= 1'b0;
            end else if (int'(idx) == gi) begin
                if (refill_done) begin
                    tag_reg   <= addr_tag;
                    valid_reg <= 1'b1;
                    dirty_reg <= 1'b0;
                end else if (write_hit) begin
                    dirty_reg <= 1'b1;
                end
            end
        end

        assign tag_vec[gi]   = tag_reg;
        assign valid_vec[gi] = valid_reg;
        assign dirty_vec[gi] = dirty_reg;
    end

    // Miss sequencing: optional write-back of a dirty victim, then refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req && !hit) begin
                        state_reg <= dirty_vec[idx] ? WRITEBACK : FETCH;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state_reg <= FETCH;
                    end
                end
                FETCH: begin
                    if (pmem_resp) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Output decode; everything is forced quiet while reset is asserted.
    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        da_write_en  = '0;
        da_datain    = '0;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        // A simultaneous read and write is serviced as a write.
                        if (mem_write) begin
                            da_write_en = {28'b0, mem_byte_enable} << {word, 2'b00};
                            da_datain   = {8{mem_wdata}};
                        end else begin
                            mem_rdata = da_dataout[{word, 5'b0} +: 32];
                        end
                    end
                end
                WRITEBACK: begin
                    pmem_write   = 1'b1;
                    pmem_address = {tag_vec[idx], idx, 5'b0};
                    pmem_wdata   = da_dataout;
                end
                FETCH: begin
                    pmem_read    = 1'b1;
                    pmem_address = {addr_tag, idx, 5'b0};
                    if (pmem_resp) begin
                        da_write_en = 32'hFFFF_FFFF;
                        da_datain   = pmem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_PERF_CTR_EN
    logic [31:0] hit_count_reg;
    logic [31:0] miss_count_reg;

    // Count completed hits and every miss that leaves IDLE; wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else if (state_reg == IDLE) begin
            if (hit) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end else if (req) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end

    assign hit_count  = rst ? 32'd0 : hit_count_reg;
    assign miss_count = rst ? 32'd0 : miss_count_reg;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Bench for l1_cache_ctrl: models the data array and physical memory, drives
// directed and random CPU accesses, and scores responses against a flat-memory
// reference plus a simple tag/valid/dirty directory.
module tb_l1_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [2:0]   da_rindex;
    logic [2:0]   da_windex;
    logic [31:0]  da_write_en;
    logic [255:0] da_datain;
    logic [255:0] da_dataout;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    l1_cache_ctrl #(.s_index(3)) dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .da_rindex(da_rindex), .da_windex(da_windex), .da_write_en(da_write_en),
        .da_datain(da_datain), .da_dataout(da_dataout),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    // Data array model: combinational read, byte-strobed write.
    logic [255:0] da_mem [8];
    assign da_dataout = da_mem[da_rindex];
    always @(posedge clk) begin
        for (int b = 0; b < 32; b++)
            if (da_write_en[b]) da_mem[da_windex][8*b +: 8] <= da_datain[8*b +: 8];
    end

    // Reference: flat word memory plus a directory of what each set holds.
    logic [31:0]  ref_mem    [logic [31:0]];
    logic [255:0] pmem_store [logic [31:0]];
    bit           ref_valid [8];
    bit           ref_dirty [8];
    logic [23:0]  ref_tag   [8];
    int           exp_hits   = 0;
    int           exp_misses = 0;

    typedef struct { bit is_read; logic [31:0] data; bit miss; } sb_t;
    typedef struct { bit wr; logic [31:0] addr; } pm_t;
    sb_t sb   [$];
    pm_t pexp [$];

    bit resp_en;
    bit presp_seen;
    always @(posedge clk) presp_seen <= pmem_resp;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEADBEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = ref_rd(a + 32'(4*w));
        return l;
    endfunction

    function automatic logic [255:0] pmem_line(input logic [31:0] a);
        logic [255:0] l;
        if (pmem_store.exists(a)) return pmem_store[a];
        for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word(a + 32'(4*w));
        return l;
    endfunction

    // Monitor: every mem_resp pops one expected response.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (mem_resp) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_resp: got mem_resp=1 addr=%h, expected none", mem_address);
                end else begin
                    e = sb.pop_front();
                    if (e.is_read && mem_rdata !== e.data) begin
                        bad++;
                        $display("FAIL rdata: addr=%h got %h expected %h", mem_address, mem_rdata, e.data);
                    end
                    if (e.miss) begin
                        total++;
                        if (!presp_seen) begin
                            bad++;
                            $display("FAIL miss_resp_timing: got pmem_resp_prev=%0d expected 1", presp_seen);
                        end
                    end
                end
            end
        end
    end

    // Physical memory responder with random latency and stability checks.
    initial begin
        logic [31:0]  a;
        bit           w;
        logic [255:0] wd;
        bit           stable;
        pm_t          p;
        int           d;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (resp_en && (pmem_read || pmem_write)) begin
                a = pmem_address; w = pmem_write; wd = pmem_wdata;
                total++;
                if (pmem_read && pmem_write) begin
                    bad++;
                    $display("FAIL pmem_both: got read=1 write=1 expected at most one");
                end
                total++;
                if (pexp.size() == 0) begin
                    bad++;
                    $display("FAIL pmem_unexpected: got wr=%0d addr=%h expected none", w, a);
                end else begin
                    p = pexp.pop_front();
                    if (p.wr != w || p.addr !== a) begin
                        bad++;
                        $display("FAIL pmem_req: got wr=%0d addr=%h expected wr=%0d addr=%h", w, a, p.wr, p.addr);
                    end
                end
                if (w) begin
                    total++;
                    if (wd !== ref_line(a)) begin
                        bad++;
                        $display("FAIL wb_data: addr=%h got %h expected %h", a, wd, ref_line(a));
                    end
                end
                stable = 1'b1;
                d = $urandom_range(0, 3);
                repeat (d) begin
                    @(negedge clk);
                    if (pmem_address !== a || pmem_write !== w || pmem_read !== !w ||
                        (w && pmem_wdata !== wd)) stable = 1'b0;
                end
                total++;
                if (!stable) begin
                    bad++;
                    $display("FAIL pmem_stable: got addr=%h rd=%0d wr=%0d expected addr=%h held", pmem_address, pmem_read, pmem_write, a);
                end
                pmem_rdata = w ? 256'b0 : pmem_line(a);
                if (w) pmem_store[a] = wd;
                pmem_resp = 1'b1;
                @(negedge clk);
                pmem_resp  = 1'b0;
                pmem_rdata = '0;
            end
        end
    end

    // One CPU access: update the reference, queue expectations, drive, wait.
    task automatic access(input logic [31:0] a, input bit rd, input bit wr,
                          input logic [3:0] be, input logic [31:0] wd, input bit want_drop);
        logic [31:0] wa;
        logic [2:0]  idx;
        logic [23:0] t;
        logic [31:0] v;
        logic [31:0] exp_en;
        bit          hit;
        bit          drop;
        int          cyc;
        sb_t         e;
        pm_t         p;
        wa   = {a[31:2], 2'b00};
        idx  = a[7:5];
        t    = a[31:8];
        hit  = ref_valid[idx] && ref_tag[idx] == t;
        drop = want_drop && !hit && !wr;
        if (!hit) begin
            if (ref_valid[idx] && ref_dirty[idx]) begin
                p.wr = 1'b1; p.addr = {ref_tag[idx], idx, 5'b0}; pexp.push_back(p);
            end
            p.wr = 1'b0; p.addr = {t, idx, 5'b0}; pexp.push_back(p);
            ref_valid[idx] = 1'b1; ref_tag[idx] = t; ref_dirty[idx] = 1'b0;
            exp_misses++;
        end
        if (!drop) begin
            if (wr) begin
                v = ref_rd(wa);
                for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
                ref_mem[wa] = v;
                ref_dirty[idx] = 1'b1;
            end
            e.is_read = !wr; e.data = ref_rd(wa); e.miss = !hit;
            sb.push_back(e);
            exp_hits++;
        end
        @(posedge clk); #1;
        mem_address = a; mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_wdata = wd;
        $display("access addr=%h rd=%0d wr=%0d be=%b wdata=%h hit=%0d drop=%0d", a, rd, wr, be, wd, hit, drop);
        if (drop) begin
            @(posedge clk); #1;
            mem_read = 1'b0;
            cyc = 0;
            while ((pexp.size() != 0 || pmem_read || pmem_write || pmem_resp) && cyc < 200) begin
                @(negedge clk); cyc++;
            end
            total++;
            if (cyc >= 200) begin
                bad++;
                $display("FAIL drop_timeout: got %0d cycles expected <200", cyc);
            end
            repeat (2) @(negedge clk);
        end else begin
            cyc = 0;
            forever begin
                @(negedge clk);
                if (mem_resp || cyc > 300) break;
                cyc++;
            end
            total++;
            if (!mem_resp) begin
                bad++;
                $display("FAIL resp_timeout: addr=%h got no mem_resp expected one", a);
            end else if ((cyc == 0) != hit) begin
                bad++;
                $display("FAIL hit_latency: addr=%h got %0d cycles expected hit=%0d", a, cyc, hit);
            end
            if (mem_resp && wr && hit) begin
                exp_en = {28'b0, be} << (4 * a[4:2]);
                total++;
                if (da_write_en !== exp_en || da_datain !== {8{wd}}) begin
                    bad++;
                    $display("FAIL write_strobe: got en=%h din=%h expected en=%h din=%h", da_write_en, da_datain[31:0], exp_en, wd);
                end
            end
            @(posedge clk); #1;
            mem_read = 1'b0; mem_write = 1'b0;
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic check_quiet(input string tag);
        check32({tag, "_mem_resp"}, {31'b0, mem_resp}, 32'd0);
        check32({tag, "_mem_rdata"}, mem_rdata, 32'd0);
        check32({tag, "_pmem_rw"}, {30'b0, pmem_read, pmem_write}, 32'd0);
        check32({tag, "_pmem_address"}, pmem_address, 32'd0);
        check32({tag, "_pmem_wdata"}, {31'b0, |pmem_wdata}, 32'd0);
        check32({tag, "_da_write_en"}, da_write_en, 32'd0);
        check32({tag, "_da_datain"}, {31'b0, |da_datain}, 32'd0);
        check32({tag, "_hit_count"}, hit_count, 32'd0);
        check32({tag, "_miss_count"}, miss_count, 32'd0);
    endtask

    initial begin
        int          cyc;
        logic [31:0] a;
        int          op;
        for (int i = 0; i < 8; i++) begin
            da_mem[i] = '0; ref_valid[i] = 1'b0; ref_dirty[i] = 1'b0; ref_tag[i] = '0;
        end
        rst = 1'b1; resp_en = 1'b1;
        mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_byte_enable = '0; mem_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("in_reset");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_quiet("after_reset");

        // Reset during a refill: request dropped, line must not be installed.
        resp_en = 1'b0;
        @(posedge clk); #1;
        mem_address = 32'h0000_0100; mem_read = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!pmem_read && cyc < 10);
        check32("rst_fetch_started", {31'b0, pmem_read}, 32'd1);
        check32("rst_fetch_addr", pmem_address, 32'h0000_0100);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check32("rst_fetch_dropped", {30'b0, pmem_read, pmem_write}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; mem_read = 1'b0; resp_en = 1'b1;
        repeat (2) @(negedge clk);

        // Directed sequence from the test plan.
        access(32'h0000_0100, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b0);
        access(32'h0000_0104, 1'b0, 1'b1, 4'b0011, 32'h1234_5678, 1'b0);
        access(32'h0000_0104, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b0);
        access(32'h0000_1100, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b0);
        access(32'h0000_1108, 1'b1, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0);
        access(32'h0000_0100, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b0);

        // Random traffic over a small footprint so sets conflict often.
        for (int n = 0; n < 300; n++) begin
            a  = {22'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00};
            op = $urandom_range(0, 2);
            access(a, op != 1, op != 0, 4'($urandom_range(0, 15)), $urandom(), $urandom_range(0, 7) == 0);
        end

        repeat (5) @(negedge clk);
        check32("sb_drained", sb.size(), 32'd0);
        check32("pexp_drained", pexp.size(), 32'd0);
`ifdef CACHE_PERF_CTR_EN
        check32("hit_count", hit_count, 32'(exp_hits));
        check32("miss_count", miss_count, 32'(exp_misses));
`else
        check32("hit_count", hit_count, 32'd0);
        check32("miss_count", miss_count, 32'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
